// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: multicycle register-register execution controller.
// Takes one instruction at a time over a valid/ready handshake, reads both
// source registers, computes the ALU result and commits it through the
// register file write port. One instruction every four cycles.
module rf_exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [1:0]  Op,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  output logic [4:0]  ReadReg1,
  output logic [4:0]  ReadReg2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic [31:0] Result,
  output logic        Done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [1:0]                Op_q;
  logic [4:0]                Rs_q;
  logic [4:0]                Rt_q;
  logic [4:0]                Rd_q;
  logic signed [DATA_W-1:0]  A;
  logic signed [DATA_W-1:0]  B;

  // ALU: ADD/SUB wrap modulo 2^32, AND is bitwise, SLT is a signed compare.
  function automatic logic [DATA_W-1:0] alu(input logic [1:0] op,
                                            input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = {{(DATA_W-1){1'b0}}, (a < b)};
    endcase
    return r;
  endfunction

  // State register and datapath latches; reset also clears the data so the
  // outputs come up at known values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      Op_q    <= '0;
      Rs_q    <= '0;
      Rt_q    <= '0;
      Rd_q    <= '0;
      A       <= '0;
      B       <= '0;
      Result  <= '0;
    end else begin
      state_q <= state_d;
      // IDLE -> READ: capture the instruction fields
      if (state_q == IDLE && InValid) begin
        Op_q <= Op;
        Rs_q <= Rs;
        Rt_q <= Rt;
        Rd_q <= Rd;
      end
      // READ -> EXEC: capture operands before any write of this instruction
      if (state_q == READ) begin
        A <= RD1;
        B <= RD2;
      end
      // EXEC -> WRITE: capture the result, held until the next EXEC
      if (state_q == EXEC) begin
        Result <= alu(Op_q, A, B);
      end
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_d  = state_q;
    InReady  = 1'b0;
    RegWrite = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_d = READ;
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: begin
        // register 0 is hardwired; reset in this cycle suppresses the commit
        RegWrite = (Rd_q != 5'd0) && !rst;
        Done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ReadReg1  = Rs_q;
  assign ReadReg2  = Rt_q;
  assign WriteReg  = Rd_q;
  assign WriteData = Result;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Testbench for rf_exec_ctrl: behavioural register file, directed scenarios
// and randomized instructions checked against a reference model.
module tb_rf_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  Op = '0;
  logic [4:0]  Rs = '0, Rt = '0, Rd = '0;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] RD1, RD2;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, Result;
  logic        Done;

  int n_cmp  = 0;
  int n_fail = 0;

  // register file attached to the DUT, with a bench preload port
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  // reference model state
  logic [31:0] exp_rf [32];
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  rf_exec_ctrl dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .RD1(RD1), .RD2(RD2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .Result(Result), .Done(Done)
  );

  assign RD1 = (ReadReg1 == 5'd0) ? 32'd0 : rf[ReadReg1];
  assign RD2 = (ReadReg2 == 5'd0) ? 32'd0 : rf[ReadReg2];

  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    else if (RegWrite && WriteReg != 5'd0) rf[WriteReg] <= WriteData;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_now(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    exp_rf[idx] = (idx == 5'd0) ? 32'd0 : val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inready"},  32'(InReady),  32'd1);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_done"},     32'(Done),     32'd0);
    chk({tag, "_rr1"},      32'(ReadReg1), 32'd0);
    chk({tag, "_rr2"},      32'(ReadReg2), 32'd0);
    chk({tag, "_wreg"},     32'(WriteReg), 32'd0);
    chk({tag, "_wdata"},    WriteData,     32'd0);
    chk({tag, "_result"},   Result,        32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (InReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready_wait"}, 32'(InReady), 32'd1);
  endtask

  // Full instruction: accept, then check each of READ/EXEC/WRITE and the
  // IDLE cycle that follows. With noise, InValid and fields are scrambled
  // while the instruction is in flight.
  task automatic issue(input string tag, input logic [1:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input bit noise);
    logic [31:0] exp;
    wait_ready(tag);
    exp = model_alu(op, exp_rf[rs], exp_rf[rt]);
    InValid = 1'b1; Op = op; Rs = rs; Rt = rt; Rd = rd;
    @(negedge clk);  // READ
    InValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) begin Op = 2'($urandom); Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom); end
    chk({tag, "_read_inready"}, 32'(InReady), 32'd0);
    chk({tag, "_rr1"}, 32'(ReadReg1), 32'(rs));
    chk({tag, "_rr2"}, 32'(ReadReg2), 32'(rt));
    chk({tag, "_read_done"}, 32'(Done), 32'd0);
    @(negedge clk);  // EXEC
    if (noise) begin
      InValid = 1'($urandom_range(0, 1));
      Op = 2'($urandom); Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
    end
    chk({tag, "_exec_inready"}, 32'(InReady), 32'd0);
    chk({tag, "_exec_regwrite"}, 32'(RegWrite), 32'd0);
    @(negedge clk);  // WRITE
    InValid = 1'b0;
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_regwrite"}, 32'(RegWrite), (rd != 5'd0) ? 32'd1 : 32'd0);
    chk({tag, "_wreg"}, 32'(WriteReg), 32'(rd));
    chk({tag, "_wdata"}, WriteData, exp);
    if (rd != 5'd0) exp_rf[rd] = exp;
    exp_result = exp;
    @(negedge clk);  // back in IDLE
    chk({tag, "_idle_inready"}, 32'(InReady), 32'd1);
    chk({tag, "_idle_done"}, 32'(Done), 32'd0);
    chk({tag, "_result"}, Result, exp_result);
    chk({tag, "_rf_rd"}, rf_now(rd), exp_rf[rd]);
  endtask

  initial begin
    logic [31:0] r7_before;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;

    // reset
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // random register contents, then the directed values
    for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
    preload(5'd2, 32'd2);
    preload(5'd3, 32'd3);
    @(negedge clk);

    // basic ADD, SUB wrap, signed SLT
    issue("add", 2'b00, 5'd2, 5'd3, 5'd1, 1'b0);
    chk("add_r1", rf_now(5'd1), 32'd5);
    issue("sub", 2'b01, 5'd2, 5'd3, 5'd4, 1'b0);
    chk("sub_r4", rf_now(5'd4), 32'hFFFF_FFFF);
    issue("slt", 2'b11, 5'd4, 5'd2, 5'd5, 1'b0);
    chk("slt_r5", rf_now(5'd5), 32'd1);

    // back-to-back with InValid held: second accept 4 edges after the first
    wait_ready("b2b");
    InValid = 1'b1; Op = 2'b00; Rs = 5'd2; Rt = 5'd3; Rd = 5'd2;
    @(negedge clk);  // READ of first
    Rs = 5'd2; Rt = 5'd2; Rd = 5'd6;
    chk("b2b_first_rr1", 32'(ReadReg1), 32'd2);
    chk("b2b_first_rr2", 32'(ReadReg2), 32'd3);
    @(negedge clk);  // EXEC
    @(negedge clk);  // WRITE
    chk("b2b_first_wdata", WriteData, 32'd5);
    chk("b2b_first_inready", 32'(InReady), 32'd0);
    @(negedge clk);  // IDLE, accepted at the coming edge
    chk("b2b_idle_inready", 32'(InReady), 32'd1);
    exp_rf[2] = 32'd5;
    @(negedge clk);  // READ of second
    InValid = 1'b0;
    chk("b2b_second_inready", 32'(InReady), 32'd0);
    chk("b2b_second_rr2", 32'(ReadReg2), 32'd2);
    chk("b2b_second_rd", 32'(WriteReg), 32'd6);
    @(negedge clk);
    @(negedge clk);  // WRITE of second
    chk("b2b_second_done", 32'(Done), 32'd1);
    chk("b2b_second_wdata", WriteData, 32'd10);
    exp_rf[6] = 32'd10;
    exp_result = 32'd10;
    @(negedge clk);
    chk("b2b_r2", rf_now(5'd2), 32'd5);
    chk("b2b_r6", rf_now(5'd6), 32'd10);

    // write to register 0 is dropped
    issue("rd0", 2'b00, 5'd2, 5'd3, 5'd0, 1'b0);
    chk("rd0_r0", rf_now(5'd0), 32'd0);

    // reset during EXEC aborts the AND
    r7_before = rf_now(5'd7);
    wait_ready("rstx");
    InValid = 1'b1; Op = 2'b10; Rs = 5'd2; Rt = 5'd3; Rd = 5'd7;
    @(negedge clk);  // READ
    InValid = 1'b0;
    @(negedge clk);  // EXEC
    rst = 1'b1;
    chk("rstx_exec_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rstx");
    chk("rstx_r7", rf_now(5'd7), r7_before);
    exp_result = 32'd0;

    // reset during WRITE suppresses the commit
    wait_ready("rstw");
    InValid = 1'b1; Op = 2'b10; Rs = 5'd2; Rt = 5'd3; Rd = 5'd7;
    @(negedge clk);
    InValid = 1'b0;
    @(negedge clk);
    @(negedge clk);  // WRITE
    chk("rstw_regwrite_pre", 32'(RegWrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rstw");
    chk("rstw_r7", rf_now(5'd7), r7_before);

    // aliasing: destination equals a source, old operand values are used
    issue("alias", 2'b01, 5'd9, 5'd10, 5'd9, 1'b0);

    // randomized instructions with in-flight input noise
    for (int i = 0; i < 60; i++) begin
      issue("rnd", 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
    end

    // final register file sweep against the model
    for (int i = 0; i < 32; i++) chk("final_rf", rf_now(5'(i)), exp_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
